cir_reg_w_ctrl: RTL and testbench
=================================

# cir_reg_w_ctrl

Sequencer for the K_H×K_W circular weight register in front of each PE. On a start command it clears the register, then accepts exactly K_W weight columns over a valid/ready handshake, generating one register load pulse per accepted column. It then rotates the register once per PE-accepted step, K_W steps per output window, for a programmed number of windows, and signals completion.

## Interface
Parameters:
- K_H, 3, kernel height; informational only, sets no widths here
- K_W, 3, kernel width; number of columns loaded and number of shifts per window; ≥2
- N_W, 16, width of the window-count field

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a job; sampled only in IDLE
- num_win  in  N_W  number of windows to run; captured on accepted start
- in_valid  in  1  upstream weight column valid
- in_ready  out  1  controller can accept a column
- pe_ready  in  1  PE consumes the current column this cycle
- reg_clear  out  1  to register clear
- reg_load_en  out  1  to register load_en
- reg_shift  out  1  to register shift
- col_idx  out  $clog2(K_W)  column currently presented to the PE, 0..K_W-1
- win_first  out  1  high while col_idx==0 in RUN
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at job end

## Operation
- States: IDLE, CLR, LOAD, RUN, DONE.
- IDLE: start=1 → capture num_win, go CLR. start in any other state is ignored.
- CLR: reg_clear=1 for exactly one cycle, load counter←0, go LOAD.
- LOAD: in_ready=1. reg_load_en = in_valid & in_ready. Each accepted beat increments the load counter. The K_W-th beat moves to RUN if captured num_win≠0, otherwise to DONE. col_idx←0, window counter←0.
- RUN: reg_shift = pe_ready. On each shift, col_idx increments and wraps K_W-1→0. On a wrap, the window counter increments. A shift at col_idx==K_W-1 with window counter==num_win-1 → DONE. After K_W shifts the register is back in its post-load rotation, so every window sees identical weights.
- pe_ready=0 in RUN: stall. No shift, counters hold.
- DONE: done=1 for one cycle, then IDLE.
- reg_load_en and reg_shift are never high in the same cycle. reg_clear is never high with either of them.
- num_win=0 is legal: clear and load still occur, with no RUN cycles.

## Timing
- Reset values: state IDLE; in_ready, reg_clear, reg_load_en, reg_shift, busy, done, win_first = 0; col_idx = 0; all counters 0.
- Reset during any state returns to IDLE on the next edge. No done pulse; no reg_clear issued. The register has its own reset.
- start accepted at edge t: CLR during cycle t+1; in_ready first high in cycle t+2.
- Minimum job length with in_valid and pe_ready held high: 1 (CLR) + K_W (LOAD) + K_W·num_win (RUN) + 1 (DONE) cycles after the start edge.
- in_ready, busy, done, col_idx and win_first are functions of registered state only.
- reg_load_en and reg_shift are combinational from state plus in_valid / pe_ready. There is no combinational path from in_valid to in_ready.
- The first cycle in IDLE after DONE can accept a new start.

## Configuration
- WCTRL_REUSE_EN defined: adds input port keep_w (1 bit) and an internal weights_valid flag.
  - weights_valid is set on completion of LOAD and cleared by rst.
  - start with keep_w=1 and weights_valid=1 skips CLR and LOAD and enters RUN directly, with col_idx=0 and window counter=0. If num_win=0, it goes straight to DONE.
  - keep_w=1 with weights_valid=0 behaves as a normal start.
- WCTRL_REUSE_EN undefined: no keep_w port; every start clears and reloads.

## Test plan
- K_W=3, num_win=2, in_valid and pe_ready held 1 → reg_clear 1 cycle; reg_load_en exactly 3 cycles; reg_shift exactly 6 cycles with col_idx 0,1,2,0,1,2; done pulses once at cycle 11 after the start edge.
- in_valid toggling 1,0,1,0,1 in LOAD → exactly 3 reg_load_en pulses, each only where in_valid=1; RUN entered after the third.
- pe_ready low for 4 cycles mid-window at col_idx=1 → no reg_shift, col_idx holds 1; the sequence resumes and the total shift count stays 3·num_win.
- num_win=0 → 1 clear, 3 loads, 0 shifts, then done.
- rst asserted during RUN at col_idx=2 → next cycle all outputs at reset values, no done; a new start runs a full clear and load.
- (WCTRL_REUSE_EN) second start with keep_w=1 after a completed job, num_win=1 → no reg_clear, no reg_load_en, 3 shifts, done; keep_w=1 directly after rst → full reload.

Source files
------------

// File: rtl/cir_reg_w_ctrl.sv
// cir_reg_w_ctrl: clear/load/rotate sequencer for a K_H x K_W circular weight register.
// Optional WCTRL_REUSE_EN adds i_keep_w to rerun windows on weights already loaded.
module cir_reg_w_ctrl #(
    parameter int K_H = 3,
    parameter int K_W = 3,
    parameter int N_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef WCTRL_REUSE_EN
    input  logic                     i_keep_w,
`endif
    input  logic                     i_start,
    input  logic [N_W-1:0]           i_num_win,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic                     i_pe_ready,
    output logic                     o_reg_clear,
    output logic                     o_reg_load_en,
    output logic                     o_reg_shift,
    output logic [$clog2(K_W)-1:0]   o_col_idx,
    output logic                     o_win_first,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int CW = $clog2(K_W);
    localparam logic [CW-1:0] LAST = CW'(K_W - 1);

    if (K_W < 2 || K_H < 1) begin : g_bad_param
        $error("cir_reg_w_ctrl: K_W must be >= 2 and K_H >= 1");
    end

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_RUN, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [N_W-1:0]  r_num_win, r_win_cnt, w_win_inc;
    logic [CW-1:0]   r_ld_cnt, r_col;
    logic            w_skip, w_ld_last, w_col_wrap, w_run_end;

`ifdef WCTRL_REUSE_EN
    logic r_wvalid;
    always_ff @(posedge clk)
        if (rst) r_wvalid <= 1'b0;
        else if (w_ld_last) r_wvalid <= 1'b1;
    assign w_skip = i_keep_w & r_wvalid;
`else
    assign w_skip = 1'b0;
`endif

    assign o_in_ready    = r_state == S_LOAD;
    assign o_reg_clear   = r_state == S_CLR;
    assign o_reg_load_en = o_in_ready & i_in_valid;
    assign o_reg_shift   = (r_state == S_RUN) & i_pe_ready;
    assign o_col_idx     = r_col;
    assign o_win_first   = (r_state == S_RUN) && r_col == '0;
    assign o_busy        = r_state != S_IDLE;
    assign o_done        = r_state == S_DONE;

    assign w_win_inc  = r_win_cnt + N_W'(1);
    assign w_ld_last  = o_reg_load_en && r_ld_cnt == LAST;
    assign w_col_wrap = o_reg_shift && r_col == LAST;
    assign w_run_end  = w_col_wrap && w_win_inc == r_num_win;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = w_skip ? ((i_num_win == '0) ? S_DONE : S_RUN) : S_CLR;
            S_CLR:   w_state_nxt = S_LOAD;
            S_LOAD:  if (w_ld_last) w_state_nxt = (r_num_win == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_run_end) w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_num_win <= '0;
            r_win_cnt <= '0;
            r_ld_cnt  <= '0;
            r_col     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && i_start) begin
                r_num_win <= i_num_win;
                r_win_cnt <= '0;
                r_col     <= '0;
            end
            if (o_reg_clear) r_ld_cnt <= '0;
            if (o_reg_load_en) r_ld_cnt <= w_ld_last ? '0 : r_ld_cnt + CW'(1);
            if (w_ld_last) begin
                r_col     <= '0;
                r_win_cnt <= '0;
            end
            // col wraps every K_W shifts so the register returns to its post-load rotation
            if (o_reg_shift) r_col <= w_col_wrap ? '0 : r_col + CW'(1);
            if (w_col_wrap) r_win_cnt <= w_win_inc;
        end
    end
endmodule

// File: tb/tb_cir_reg_w_ctrl.sv
// tb_cir_reg_w_ctrl: directed tests for cir_reg_w_ctrl with K_W=3.
module tb_cir_reg_w_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, in_valid, pe_ready, keep_w;
    logic [15:0] num_win;
    logic        in_ready, reg_clear, reg_load_en, reg_shift, win_first, busy, done;
    logic [1:0]  col_idx;

    int n_vec = 0, n_err = 0;
    int n_clr, n_ld, n_sh, n_rdy, n_ovl, n_bad_ld, n_stall, done_cyc, first_sh;
    logic [31:0] col_pk, wf_pk, stall_pk;

    always #5 clk = ~clk;

    cir_reg_w_ctrl #(.K_H(3), .K_W(3), .N_W(16)) dut (
        .clk(clk),
        .rst(rst),
`ifdef WCTRL_REUSE_EN
        .i_keep_w(keep_w),
`endif
        .i_start(start),
        .i_num_win(num_win),
        .i_in_valid(in_valid),
        .o_in_ready(in_ready),
        .i_pe_ready(pe_ready),
        .o_reg_clear(reg_clear),
        .o_reg_load_en(reg_load_en),
        .o_reg_shift(reg_shift),
        .o_col_idx(col_idx),
        .o_win_first(win_first),
        .o_busy(busy),
        .o_done(done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Runs one job from an IDLE cycle; masks give in_valid/pe_ready per cycle after the start edge.
    task automatic run_job(input logic [15:0] nw, input logic [63:0] ivm, input logic [63:0] pem);
        n_clr = 0; n_ld = 0; n_sh = 0; n_rdy = 0; n_ovl = 0; n_bad_ld = 0; n_stall = 0;
        done_cyc = 0; first_sh = 0; col_pk = 0; wf_pk = 0; stall_pk = 0;
        start = 1'b1; num_win = nw;
        tick();
        start = 1'b0;
        for (int c = 1; c < 60 && done_cyc == 0; c++) begin
            in_valid = ivm[c]; pe_ready = pem[c];
            #1;
            n_clr += int'(reg_clear); n_ld += int'(reg_load_en); n_sh += int'(reg_shift); n_rdy += int'(in_ready);
            if (reg_load_en && !in_valid) n_bad_ld++;
            if ((reg_load_en && reg_shift) || (reg_clear && (reg_load_en || reg_shift))) n_ovl++;
            if (reg_shift) begin
                col_pk = {col_pk[29:0], col_idx};
                wf_pk = {wf_pk[30:0], win_first};
                if (first_sh == 0) first_sh = c;
            end
            if (!pe_ready) begin
                n_stall++;
                stall_pk = {stall_pk[29:0], col_idx};
            end
            if (done) done_cyc = c;
            tick();
        end
        in_valid = 1'b0; pe_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; num_win = 16'd5; in_valid = 1'b1; pe_ready = 1'b1; keep_w = 1'b0;
        tick(); tick();
        n_vec++; if ({in_ready, reg_clear, reg_load_en, reg_shift} !== 4'b0) begin n_err++; $display("FAIL reset_strobes: got %b expected 0000", {in_ready, reg_clear, reg_load_en, reg_shift}); end
        n_vec++; if ({busy, done, win_first, col_idx} !== 5'b0) begin n_err++; $display("FAIL reset_status: got %b expected 00000", {busy, done, win_first, col_idx}); end
        rst = 1'b0; in_valid = 1'b0; pe_ready = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        run_job(16'd2, '1, '1);
        n_vec++; if (n_clr !== 1) begin n_err++; $display("FAIL basic_clear: got %0d expected 1", n_clr); end
        n_vec++; if (n_ld !== 3) begin n_err++; $display("FAIL basic_loads: got %0d expected 3", n_ld); end
        n_vec++; if (n_rdy !== 3) begin n_err++; $display("FAIL basic_ready: got %0d expected 3", n_rdy); end
        n_vec++; if (n_sh !== 6) begin n_err++; $display("FAIL basic_shifts: got %0d expected 6", n_sh); end
        n_vec++; if (col_pk !== 32'h186) begin n_err++; $display("FAIL basic_col_seq: got %h expected 186", col_pk); end
        n_vec++; if (wf_pk !== 32'h24) begin n_err++; $display("FAIL basic_win_first: got %h expected 24", wf_pk); end
        n_vec++; if (first_sh !== 5) begin n_err++; $display("FAIL basic_first_shift: got %0d expected 5", first_sh); end
        n_vec++; if (done_cyc !== 11) begin n_err++; $display("FAIL basic_done_cycle: got %0d expected 11", done_cyc); end
        n_vec++; if (n_ovl !== 0) begin n_err++; $display("FAIL basic_overlap: got %0d expected 0", n_ovl); end
    endtask

    task automatic test_valid_toggle;
        run_job(16'd2, 64'h54, '1);
        n_vec++; if (n_ld !== 3) begin n_err++; $display("FAIL toggle_loads: got %0d expected 3", n_ld); end
        n_vec++; if (n_bad_ld !== 0) begin n_err++; $display("FAIL toggle_load_wo_valid: got %0d expected 0", n_bad_ld); end
        n_vec++; if (n_rdy !== 5) begin n_err++; $display("FAIL toggle_ready: got %0d expected 5", n_rdy); end
        n_vec++; if (first_sh !== 7) begin n_err++; $display("FAIL toggle_first_shift: got %0d expected 7", first_sh); end
        n_vec++; if (done_cyc !== 13) begin n_err++; $display("FAIL toggle_done_cycle: got %0d expected 13", done_cyc); end
    endtask

    task automatic test_stall;
        run_job(16'd2, '1, ~64'h3C0);
        n_vec++; if (n_sh !== 6) begin n_err++; $display("FAIL stall_shifts: got %0d expected 6", n_sh); end
        n_vec++; if (col_pk !== 32'h186) begin n_err++; $display("FAIL stall_col_seq: got %h expected 186", col_pk); end
        n_vec++; if (stall_pk !== 32'h55 || n_stall !== 4) begin n_err++; $display("FAIL stall_col_hold: got %h/%0d expected 55/4", stall_pk, n_stall); end
        n_vec++; if (done_cyc !== 15) begin n_err++; $display("FAIL stall_done_cycle: got %0d expected 15", done_cyc); end
    endtask

    task automatic test_num_win_zero;
        run_job(16'd0, '1, '1);
        n_vec++; if ({n_clr, n_ld, n_sh} !== {32'd1, 32'd3, 32'd0}) begin n_err++; $display("FAIL zero_counts: got clr=%0d ld=%0d sh=%0d expected 1/3/0", n_clr, n_ld, n_sh); end
        n_vec++; if (done_cyc !== 5) begin n_err++; $display("FAIL zero_done_cycle: got %0d expected 5", done_cyc); end
    endtask

    task automatic test_back_to_back;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got busy=%b expected 0", busy); end
        run_job(16'd1, '1, '1);
        n_vec++; if ({n_clr, n_sh} !== {32'd1, 32'd3}) begin n_err++; $display("FAIL b2b_counts: got clr=%0d sh=%0d expected 1/3", n_clr, n_sh); end
        n_vec++; if (done_cyc !== 8) begin n_err++; $display("FAIL b2b_done_cycle: got %0d expected 8", done_cyc); end
    endtask

    task automatic test_reset_mid_run;
        int seen, dones;
        seen = 0; dones = 0;
        start = 1'b1; num_win = 16'd2; in_valid = 1'b1; pe_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 20 && seen == 0; c++) begin
            #1;
            if (busy && col_idx == 2'd2) seen = c;
            else tick();
        end
        n_vec++; if (seen !== 7) begin n_err++; $display("FAIL rstrun_reach_col2: got cycle %0d expected 7", seen); end
        rst = 1'b1;
        tick();
        n_vec++; if ({in_ready, reg_clear, reg_load_en, reg_shift, busy, done, win_first, col_idx} !== 9'b0) begin n_err++; $display("FAIL rstrun_outputs: got %b expected 000000000", {in_ready, reg_clear, reg_load_en, reg_shift, busy, done, win_first, col_idx}); end
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            dones += int'(done) + int'(busy);
        end
        n_vec++; if (dones !== 0) begin n_err++; $display("FAIL rstrun_quiet: got %0d done/busy cycles expected 0", dones); end
        in_valid = 1'b0; pe_ready = 1'b0;
        run_job(16'd1, '1, '1);
        n_vec++; if ({n_clr, n_ld} !== {32'd1, 32'd3}) begin n_err++; $display("FAIL rstrun_reload: got clr=%0d ld=%0d expected 1/3", n_clr, n_ld); end
        n_vec++; if (done_cyc !== 8) begin n_err++; $display("FAIL rstrun_done_cycle: got %0d expected 8", done_cyc); end
    endtask

`ifdef WCTRL_REUSE_EN
    task automatic test_reuse;
        keep_w = 1'b1;
        run_job(16'd1, '1, '1);
        n_vec++; if ({n_clr, n_ld, n_sh} !== {32'd0, 32'd0, 32'd3}) begin n_err++; $display("FAIL reuse_counts: got clr=%0d ld=%0d sh=%0d expected 0/0/3", n_clr, n_ld, n_sh); end
        n_vec++; if (done_cyc !== 4) begin n_err++; $display("FAIL reuse_done_cycle: got %0d expected 4", done_cyc); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        run_job(16'd1, '1, '1);
        n_vec++; if ({n_clr, n_ld, n_sh} !== {32'd1, 32'd3, 32'd3}) begin n_err++; $display("FAIL reuse_after_rst: got clr=%0d ld=%0d sh=%0d expected 1/3/3", n_clr, n_ld, n_sh); end
        n_vec++; if (done_cyc !== 8) begin n_err++; $display("FAIL reuse_after_rst_done: got %0d expected 8", done_cyc); end
        keep_w = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_valid_toggle();
        test_stall();
        test_num_win_zero();
        test_back_to_back();
        test_reset_mid_run();
`ifdef WCTRL_REUSE_EN
        test_reuse();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
